// File: rtl/fetch_ext_mb_loader.sv
// Loads one 16x16 luma macroblock from external frame memory as 32 eight-byte reads
// and streams the returned words to the search-window fetch stage in its write order.
module fetch_ext_mb_loader #(
    parameter int AW      = 32,
    parameter int DW      = 64,
    parameter int XW      = 8,
    parameter int YW      = 8,
    parameter int MAX_OUT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] frame_base_i,
    input  logic [XW-1:0] sys_total_x_i,
    input  logic          ext_start_i,
    input  logic [XW-1:0] ext_mb_x_i,
    input  logic [YW-1:0] ext_mb_y_i,
    output logic          ext_valid_o,
    output logic [DW-1:0] ext_data_o,
    output logic          ext_done_o,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic          mem_ack_i,
    input  logic          mem_rvalid_i,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam int OW = 4;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE,
        RELEASE
    } state_t;

    state_t state_reg, state_next;

    logic [AW-1:0] origin_reg;
    logic [AW-1:0] stride_reg;
    logic [5:0]    req_cnt_reg;
    logic [5:0]    beat_cnt_reg;
    logic [OW-1:0] out_reg, out_next;
    logic          req_reg;
    logic [AW-1:0] addr_reg;
    logic          valid_reg;
    logic [DW-1:0] data_reg;
    logic          done_reg;

    logic          fire;
    logic          ret;
    logic          accept_cmd;
    logic          raise;
    logic [5:0]    idx;
    logic [4:0]    row;
    logic [AW-1:0] stride_in;
    logic [AW-1:0] origin_in;
    logic [AW-1:0] addr_calc;

    assign fire       = req_reg & mem_ack_i;
    assign ret        = mem_rvalid_i & ((state_reg == RUN) || (state_reg == DRAIN))
                        & (out_reg != '0);
    assign accept_cmd = (state_reg == IDLE) & ext_start_i;

    // Row stride in bytes and the byte address of the MB's top-left pixel, captured
    // once per command so the per-request address only needs a small row multiply.
    assign stride_in = (AW'(sys_total_x_i) + AW'(1)) << 4;
    assign origin_in = frame_base_i
                     + ((AW'(ext_mb_y_i) * stride_in) << 4)
                     + (AW'(ext_mb_x_i) << 4);

    // Index of the request to present next: one further on if the current one is
    // being accepted this cycle.
    assign idx       = fire ? (req_cnt_reg + 6'd1) : req_cnt_reg;
    assign row       = {idx[4:3], idx[1:0]};
    assign addr_calc = origin_reg + AW'(row) * stride_reg + AW'({idx[2], 3'b000});

    // The outstanding limit gates only the raising of a request; a raised request
    // is held until accepted.
    assign raise = (state_reg == RUN) & (~req_reg | fire) & (idx < 6'd32)
                   & (out_next < OW'(MAX_OUT));

    always_comb begin
        out_next = out_reg;
        if (fire && !ret) begin
            out_next = out_reg + 1'b1;
        end else if (!fire && ret) begin
            out_next = out_reg - 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (ext_start_i) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (fire && (req_cnt_reg == 6'd31)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (ret && (beat_cnt_reg == 6'd31)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = RELEASE;
            end
            RELEASE: begin
                if (!ext_start_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            origin_reg   <= '0;
            stride_reg   <= '0;
            req_cnt_reg  <= '0;
            beat_cnt_reg <= '0;
            out_reg      <= '0;
            req_reg      <= 1'b0;
            addr_reg     <= '0;
            valid_reg    <= 1'b0;
            data_reg     <= '0;
            done_reg     <= 1'b0;
        end else begin
            out_reg <= out_next;

            if (accept_cmd) begin
                origin_reg   <= origin_in;
                stride_reg   <= stride_in;
                req_cnt_reg  <= '0;
                beat_cnt_reg <= '0;
            end else begin
                if (fire) begin
                    req_cnt_reg <= req_cnt_reg + 6'd1;
                end
                if (ret) begin
                    beat_cnt_reg <= beat_cnt_reg + 6'd1;
                end
            end

            if (raise) begin
                req_reg  <= 1'b1;
                addr_reg <= addr_calc;
            end else if (fire) begin
                req_reg  <= 1'b0;
            end

            valid_reg <= ret;
            if (ret) begin
                data_reg <= mem_rdata_i;
            end

            // Registered so the pulse lands the cycle after the final beat.
            done_reg <= (state_reg == DONE);
        end
    end

    assign mem_req_o   = req_reg;
    assign mem_addr_o  = addr_reg;
    assign ext_valid_o = valid_reg;
    assign ext_data_o  = data_reg;
    assign ext_done_o  = done_reg;

endmodule

// File: doc/fetch_ext_mb_loader.md
Name: fetch_ext_mb_loader

Overview:
- Upstream feeder of the luma search-window fetch stage. Accepts one-MB load commands (start, mb_x, mb_y).
- Issues 32 8-byte reads per command to external frame memory over an in-order request/response port.
- Streams the returned 64-bit words back to the fetch stage in that stage's fixed write order, then pulses done.
- One command in flight at a time. The sink always accepts data.

Parameters:
AW, 32, external memory byte-address width
DW, 64, data width (8 pixels x 8-bit BIT_DEPTH)
XW, 8, MB x-coordinate width (PIC_W_MB_LEN)
YW, 8, MB y-coordinate width (PIC_H_MB_LEN)
MAX_OUT, 4, maximum accepted-but-unreturned read requests (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
frame_base_i  in  AW  byte address of pixel (0,0) of reference luma frame; sampled at command accept
sys_total_x_i  in  XW  index of last MB column (picture width = (sys_total_x_i+1)*16 bytes); sampled at command accept
ext_start_i  in  1  level load request; held high until done seen
ext_mb_x_i  in  XW  MB column to load; valid while ext_start_i high
ext_mb_y_i  in  YW  MB row to load; valid while ext_start_i high
ext_valid_o  out  1  data beat valid
ext_data_o  out  DW  data beat; byte 0 = leftmost pixel
ext_done_o  out  1  one-cycle pulse, MB complete
mem_req_o  out  1  read request
mem_addr_o  out  AW  read byte address, 8-byte aligned
mem_ack_i  in  1  request accepted when mem_req_o & mem_ack_i
mem_rvalid_i  in  1  read data valid, returned in request order
mem_rdata_i  in  DW  read data

Behaviour:
- Reset: all outputs 0; FSM IDLE; all counters 0. Reset mid-command aborts it; no done is issued. Data returning after reset is ignored.
- FSM states: IDLE, RUN, DRAIN, DONE, RELEASE.
  - IDLE: when ext_start_i=1, latch mb_x, mb_y, frame_base, total_x, then go to RUN. The request counter req_cnt and beat counter beat_cnt are cleared.
  - RUN: issue requests. Go to DRAIN on acceptance of request 31.
  - DRAIN: wait for the remaining returns. Go to DONE when beat 31 is returned.
  - DONE: ext_done_o=1 for exactly one cycle, then go to RELEASE.
  - RELEASE: wait until ext_start_i=0, then go to IDLE. This prevents a stale start, still high in the cycle after done, from relaunching the MB.
- Request order: request k (0..31) uses g=k>>3, h=(k>>2)&1, r=4g+(k&3).
  - Order is rows 0-3 left half, rows 0-3 right half, rows 4-7 left half, and so on.
  - mem_addr_o = frame_base + (mb_y*16 + r)*(total_x+1)*16 + mb_x*16 + h*8.
  - Computed at AW bits; wraps modulo 2^AW.
  - The address must be registered; no combinational path from ext_* inputs to mem_addr_o.
- Request handshake:
  - mem_req_o and mem_addr_o stay stable until accepted.
  - mem_req_o=1 only in RUN and only while outstanding < MAX_OUT. Outstanding = accepted minus returned.
  - On simultaneous accept and return, outstanding is unchanged.
  - Once raised, mem_req_o is not dropped before acceptance. The outstanding check applies only when raising it.
- Data path:
  - ext_valid_o and ext_data_o are registered copies of mem_rvalid_i and mem_rdata_i, with 1-cycle latency.
  - Forwarded only in RUN/DRAIN with outstanding > 0. Otherwise mem_rvalid_i is ignored and does not decrement.
  - Exactly 32 ext_valid_o beats per command.
- Done: ext_done_o rises in the cycle after the 32nd ext_valid_o beat and lasts one cycle.
- ext_start_i dropping mid-command is ignored; the command completes.
- ext_mb_x_i and ext_mb_y_i changes after accept are ignored.
- No valid beats appear between done and the next command's first beat.

Test Plan:
- Base, single MB: base=0x1000, total_x=3, MB(0,0), ack tied 1, rdata returned 2 cycles after accept.
  - Required addresses: 0x1000, 0x1040, 0x1080, 0x10C0, 0x1008, 0x1048, ..., then req8=0x1100, ..., last=0x13C8.
  - 32 ext_valid_o beats, then ext_done_o one cycle after the last beat.
- Offset MB: base=0, total_x=3, MB(2,1) -> req0=0x420 (1056), req4=0x428, req31=0x7E8.
- Throttle: ack asserted 1 of 3 cycles, read latency 10 cycles.
  - Outstanding never exceeds 4 (MAX_OUT).
  - mem_addr_o stable while req is unacked.
  - Data order matches requests; exactly 32 beats, 1 done.
- Back-to-back: start held through the done cycle plus 1, low 2 cycles, then high for MB(1,0).
  - Only one done for the first MB; the second load starts only after start falls.
  - Second load req0 = base+16.
- Spurious/abort: rvalid pulses in IDLE produce no ext_valid_o. rst_n low after beat 10 gives all outputs 0 and no done. The next start runs a clean full 32-beat load.
- Wrap: base=0xFFFF_FFF8, MB(0,0) -> req0=0xFFFF_FFF8, req4=0x0000_0000 (modulo 2^32).
